// File: rtl/data_mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : Access sizes and FSM state encoding for data_mem_access_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    typedef enum logic [1:0] {
        MEM_B    = 2'b00,
        MEM_H    = 2'b01,
        MEM_W    = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_t;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_ACCESS = 4'b0010,
        ST_WAIT   = 4'b0100,
        ST_RESP   = 4'b1000
    } state_t;

    // Reserved size behaves as a word, so it shares the word alignment rule.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lane);
        logic r;
        case (size)
            MEM_B:   r = 1'b0;
            MEM_H:   r = lane[0];
            default: r = |lane;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_access_unit_if
//  Description : Core request/response handshake plus data SRAM port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_adel;
    logic        resp_ades;
    logic [31:0] resp_badvaddr;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    // master: core plus SRAM environment; slave: the access unit
    modport master (
        output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, data_sram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_adel, resp_ades, resp_badvaddr,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, data_sram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_adel, resp_ades, resp_badvaddr,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_access_unit_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Selects the addressed byte/half of a loaded word and extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (size)
            MEM_B:   data = is_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            MEM_H:   data = is_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_access_unit
//  Description : One-at-a-time load/store unit between the core and data SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    data_mem_access_unit_if.slave  bus
);

    localparam int         C_LAT       = (RD_LATENCY < 1) ? 1 : ((RD_LATENCY > 3) ? 3 : RD_LATENCY);
    localparam logic [1:0] C_WAIT_INIT = 2'(C_LAT - 1);

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_wr;
    logic        r_uns;
    mem_size_t   r_size;
    logic [1:0]  r_lane;

    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_adel;
    logic        r_ades;
    logic [31:0] r_badvaddr;

    logic        r_sram_en;
    logic [3:0]  r_sram_wen;
    logic [31:0] r_sram_addr;
    logic [31:0] r_sram_wdata;

    mem_size_t   w_size;
    logic [1:0]  w_lane;
    logic        w_misaligned;
    logic [3:0]  w_store_wen;
    logic [31:0] w_store_wdata;
    logic [31:0] w_load_data;

    assign w_size       = mem_size_t'(bus.req_size);
    assign w_lane       = bus.req_addr[1:0];
    assign w_misaligned = is_misaligned(w_size, w_lane);

    // Store data is replicated across lanes so the SRAM only needs byte enables.
    always_comb begin
        w_store_wen   = 4'b1111;
        w_store_wdata = bus.req_wdata;
        case (w_size)
            MEM_B: begin
                w_store_wen   = 4'b0001 << w_lane;
                w_store_wdata = {4{bus.req_wdata[7:0]}};
            end
            MEM_H: begin
                w_store_wen   = w_lane[1] ? 4'b1100 : 4'b0011;
                w_store_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                w_store_wen   = 4'b1111;
                w_store_wdata = bus.req_wdata;
            end
        endcase
    end

    load_align u_load_align (
        .rdata       (bus.data_sram_rdata),
        .addr        (r_lane),
        .size        (r_size),
        .is_unsigned (r_uns),
        .data        (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 2'd0;
            r_wr         <= 1'b0;
            r_uns        <= 1'b0;
            r_size       <= MEM_B;
            r_lane       <= 2'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_adel       <= 1'b0;
            r_ades       <= 1'b0;
            r_badvaddr   <= 32'd0;
            r_sram_en    <= 1'b0;
            r_sram_wen   <= 4'd0;
            r_sram_addr  <= 32'd0;
            r_sram_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_wr         <= bus.req_wr;
                        r_uns        <= bus.req_unsigned;
                        r_size       <= w_size;
                        r_lane       <= w_lane;
                        r_req_ready  <= 1'b0;
                        r_sram_addr  <= {bus.req_addr[31:2], 2'b00};
                        r_sram_wdata <= w_store_wdata;
                        if (w_misaligned) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= 32'd0;
                            r_adel       <= ~bus.req_wr;
                            r_ades       <= bus.req_wr;
                            r_badvaddr   <= bus.req_addr;
                        end else begin
                            r_state    <= ST_ACCESS;
                            r_sram_en  <= 1'b1;
                            r_sram_wen <= bus.req_wr ? w_store_wen : 4'd0;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_sram_en  <= 1'b0;
                    r_sram_wen <= 4'd0;
                    if (r_wr) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= 32'd0;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= C_WAIT_INIT;
                    end
                end
                ST_WAIT: begin
                    // SRAM data is valid during the final wait cycle only.
                    if (r_cnt == 2'd0) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load_data;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= 32'd0;
                        r_adel       <= 1'b0;
                        r_ades       <= 1'b0;
                        r_badvaddr   <= 32'd0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_sram_en    <= 1'b0;
                    r_sram_wen   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.req_ready       = r_req_ready;
    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_rdata      = r_resp_rdata;
    assign bus.resp_adel       = r_adel;
    assign bus.resp_ades       = r_ades;
    assign bus.resp_badvaddr   = r_badvaddr;
    // Gating by reset keeps a stray access from hitting the SRAM in a reset cycle.
    assign bus.data_sram_en    = r_sram_en & ~reset;
    assign bus.data_sram_wen   = r_sram_wen & {4{~reset}};
    assign bus.data_sram_addr  = r_sram_addr;
    assign bus.data_sram_wdata = r_sram_wdata;

endmodule
`default_nettype wire
